// File: rtl/strip_tile_display_if.sv
// Command and video bus shared by strip_tile_display and its driver.
// The slave side takes commands and scan position and returns pixel colour and status.
interface strip_tile_display_if;
  logic        write_valid;
  logic [31:0] writedata;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic [23:0] RGB_output;
  logic        active_bank;
  logic        cmd_err;

  modport slave (
    input  write_valid, writedata, hcount, vcount,
    output RGB_output, active_bank, cmd_err
  );

  modport master (
    output write_valid, writedata, hcount, vcount,
    input  RGB_output, active_bank, cmd_err
  );
endinterface

// File: rtl/strip_tile_display.sv
// Tiled horizontal strip renderer: double-buffered per-strip config, X scroll, gaps,
// 2-bpp pattern ROM with a 4-entry palette, three-stage pixel pipeline.
module strip_tile_display #(
  parameter logic [5:0]  COMPONENT_ID = 6'b001111,
  parameter int unsigned NUM_STRIPS   = 2,
  parameter int unsigned NUM_GAPS     = 2,
  parameter int unsigned STRIP_H      = 32,
  parameter int unsigned TILE_W       = 16,
  parameter int unsigned TILE_H       = 16,
  parameter int unsigned NUM_PATTERNS = 1,
  parameter logic [9:0]  SWAP_LINE    = 10'd480,
  parameter logic [23:0] BG_COLOR     = 24'h202020,
  parameter logic [2*NUM_PATTERNS*TILE_W*TILE_H-1:0] ROM_INIT =
    {(NUM_PATTERNS*TILE_W*TILE_H/2){4'b1001}}
) (
  input  logic clk,
  input  logic reset,
  strip_tile_display_if.slave bus
);
  localparam int unsigned TWB = $clog2(TILE_W);
  localparam int unsigned THB = $clog2(TILE_H);
  localparam int unsigned PIX = NUM_PATTERNS * TILE_W * TILE_H;
  localparam int unsigned AW  = $clog2(PIX / 2);
  localparam int unsigned IW  = AW + 1;
  localparam int unsigned PW  = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1;
  localparam logic [5:0] NS6 = 6'(NUM_STRIPS);
  localparam logic [3:0] NG4 = 4'(NUM_GAPS);
  localparam logic [5:0] NP6 = 6'(NUM_PATTERNS);

  logic          en_q  [2][NUM_STRIPS];
  logic          hf_q  [2][NUM_STRIPS];
  logic [PW-1:0] pat_q [2][NUM_STRIPS];
  logic [9:0]    xs_q  [2][NUM_STRIPS];
  logic [9:0]    yt_q  [2][NUM_STRIPS];
  logic [9:0]    gl_q  [2][NUM_STRIPS][NUM_GAPS];
  logic [9:0]    gr_q  [2][NUM_STRIPS][NUM_GAPS];

  logic active_bank_q, pend_q, pend_bank_q, err_q;

  logic [5:0]  sub;
  logic [4:0]  strip;
  logic [3:0]  info;
  logic [2:0]  typ;
  logic        bank;
  logic [12:0] msg;
  logic        is_swap, is_strip, bad, pat_oob, wr, err_set, commit;

  always_comb begin
    {sub, strip, info, typ, bank, msg} = bus.writedata;
    is_swap  = bus.write_valid && (info == 4'hF);
    is_strip = bus.write_valid && (info == 4'h1) && (sub == COMPONENT_ID);
    // Bank check uses the pre-commit active bank, so a same-cycle commit cannot open a write.
    bad      = (bank == active_bank_q) || ({1'b0, strip} >= NS6) ||
               (((typ == 3'b100) || (typ == 3'b101)) && ({1'b0, msg[12:10]} >= NG4));
    pat_oob  = (typ == 3'b001) && ({1'b0, msg[4:0]} >= NP6);
    wr       = is_strip && !bad;
    err_set  = is_strip && (bad || pat_oob);
    commit   = pend_q && (bus.hcount == '0) && (bus.vcount == SWAP_LINE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned b = 0; b < 2; b++) begin
        for (int unsigned s = 0; s < NUM_STRIPS; s++) begin
          en_q[b][s]  <= 1'b0;
          hf_q[b][s]  <= 1'b0;
          pat_q[b][s] <= '0;
          xs_q[b][s]  <= '0;
          yt_q[b][s]  <= '0;
          for (int unsigned g = 0; g < NUM_GAPS; g++) begin
            gl_q[b][s][g] <= '1;
            gr_q[b][s][g] <= '0;
          end
        end
      end
    end else if (wr) begin
      for (int unsigned b = 0; b < 2; b++) begin
        for (int unsigned s = 0; s < NUM_STRIPS; s++) begin
          if ((bank == 1'(b)) && (strip == 5'(s))) begin
            case (typ)
              3'b001: begin
                en_q[b][s] <= msg[12];
                hf_q[b][s] <= msg[11];
                if (!pat_oob) pat_q[b][s] <= msg[PW-1:0];
              end
              3'b010: xs_q[b][s] <= msg[9:0];
              3'b011: yt_q[b][s] <= msg[9:0];
              3'b100, 3'b101: begin
                for (int unsigned g = 0; g < NUM_GAPS; g++) begin
                  if (msg[12:10] == 3'(g)) begin
                    if (typ == 3'b100) gl_q[b][s][g] <= msg[9:0];
                    else               gr_q[b][s][g] <= msg[9:0];
                  end
                end
              end
              default: ;
            endcase
          end
        end
      end
    end
  end

  // A swap in the commit cycle re-arms pending after the commit has consumed the old bank.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active_bank_q <= 1'b0;
      pend_q        <= 1'b0;
      pend_bank_q   <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      if (commit) begin
        active_bank_q <= pend_bank_q;
        pend_q        <= 1'b0;
      end
      if (is_swap) begin
        pend_q      <= 1'b1;
        pend_bank_q <= bank;
      end
      if (err_set) err_q <= 1'b1;
    end
  end

  logic [NUM_STRIPS-1:0] hit_s, gap_s;
  logic [IW-1:0]         idx_s [NUM_STRIPS];
  logic                  hit_d;
  logic [IW-1:0]         idx_d;

  always_comb begin
    for (int unsigned s = 0; s < NUM_STRIPS; s++) begin
      gap_s[s] = 1'b0;
      for (int unsigned g = 0; g < NUM_GAPS; g++) begin
        if ((gl_q[active_bank_q][s][g] <= gr_q[active_bank_q][s][g]) &&
            (bus.hcount >= gl_q[active_bank_q][s][g]) &&
            (bus.hcount <= gr_q[active_bank_q][s][g]))
          gap_s[s] = 1'b1;
      end
      hit_s[s] = en_q[active_bank_q][s] && !gap_s[s] &&
                 ({1'b0, bus.vcount} >= {1'b0, yt_q[active_bank_q][s]}) &&
                 ({1'b0, bus.vcount} < ({1'b0, yt_q[active_bank_q][s]} + 11'(STRIP_H)));
      // Mirroring within a power-of-2 tile is a bitwise invert of the column.
      idx_s[s] = IW'(pat_q[active_bank_q][s]) * IW'(TILE_W * TILE_H) +
                 IW'({THB'(bus.vcount - yt_q[active_bank_q][s]),
                      TWB'(bus.hcount + xs_q[active_bank_q][s]) ^ {TWB{hf_q[active_bank_q][s]}}});
    end
    hit_d = 1'b0;
    idx_d = '0;
    for (int unsigned i = 0; i < NUM_STRIPS; i++) begin
      if (hit_s[NUM_STRIPS-1-i]) begin
        hit_d = 1'b1;
        idx_d = idx_s[NUM_STRIPS-1-i];
      end
    end
  end

  logic          hit1_q, odd1_q, hit2_q, odd2_q;
  logic [AW-1:0] word1_q;
  logic [3:0]    nib2_q;
  logic [1:0]    px2;
  logic [23:0]   rgb_q, rgb_d;

  always_comb begin
    px2 = odd2_q ? nib2_q[3:2] : nib2_q[1:0];
    case (px2)
      2'd0:    rgb_d = 24'h202020;
      2'd1:    rgb_d = 24'hFFFFFF;
      2'd2:    rgb_d = 24'h808080;
      default: rgb_d = 24'hD3D3D3;
    endcase
    if (!hit2_q) rgb_d = BG_COLOR;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit1_q  <= 1'b0;
      odd1_q  <= 1'b0;
      word1_q <= '0;
      hit2_q  <= 1'b0;
      odd2_q  <= 1'b0;
      nib2_q  <= '0;
      rgb_q   <= BG_COLOR;
    end else begin
      hit1_q  <= hit_d;
      odd1_q  <= idx_d[0];
      word1_q <= idx_d[IW-1:1];
      hit2_q  <= hit1_q;
      odd2_q  <= odd1_q;
      nib2_q  <= ROM_INIT[{word1_q, 2'b00} +: 4];
      rgb_q   <= rgb_d;
    end
  end

  assign bus.RGB_output  = rgb_q;
  assign bus.active_bank = active_bank_q;
  assign bus.cmd_err     = err_q;
endmodule

// File: tb/tb_strip_tile_display.sv
// Bench for strip_tile_display: directed scenarios plus randomized commands and scan
// positions, checked every cycle against a pixel-level reference model.
module tb_strip_tile_display;
  localparam int NS = 2, NG = 2, NP = 2, SH = 32, TW = 16, TH = 16;
  localparam logic [5:0]  ID = 6'b001111;
  localparam logic [23:0] BG = 24'h202020;

  function automatic logic [1023:0] make_rom();
    logic [1023:0] r;
    for (int i = 0; i < 256; i++) r[4*i +: 4] = 4'(i*7 + (i >> 3)*3 + 1);
    return r;
  endfunction
  localparam logic [1023:0] ROM = make_rom();

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  strip_tile_display_if bus();

  strip_tile_display #(
    .COMPONENT_ID(ID), .NUM_STRIPS(NS), .NUM_GAPS(NG), .STRIP_H(SH),
    .TILE_W(TW), .TILE_H(TH), .NUM_PATTERNS(NP), .SWAP_LINE(10'd480),
    .BG_COLOR(BG), .ROM_INIT(ROM)
  ) dut (.clk(clk), .reset(reset), .bus(bus));

  int m_act, m_pend, m_pbank, m_err;
  int m_en[2][NS], m_hf[2][NS], m_pat[2][NS], m_xs[2][NS], m_yt[2][NS];
  int m_gl[2][NS][NG], m_gr[2][NS][NG];
  logic [23:0] expq[$];
  int n_chk = 0, n_pass = 0;

  task automatic check(string name, logic [23:0] got, logic [23:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
  endtask

  function automatic logic [23:0] pal(logic [1:0] px);
    case (px)
      2'd0: return 24'h202020;
      2'd1: return 24'hFFFFFF;
      2'd2: return 24'h808080;
      default: return 24'hD3D3D3;
    endcase
  endfunction

  function automatic logic [23:0] model_pix(int hc, int vc);
    logic [1023:0] rv;
    int col, row, idx;
    bit gapped;
    rv = ROM;
    for (int s = 0; s < NS; s++) begin
      if (m_en[m_act][s] == 0) continue;
      if (vc < m_yt[m_act][s] || vc >= m_yt[m_act][s] + SH) continue;
      gapped = 0;
      for (int g = 0; g < NG; g++)
        if (m_gl[m_act][s][g] <= m_gr[m_act][s][g] &&
            hc >= m_gl[m_act][s][g] && hc <= m_gr[m_act][s][g]) gapped = 1;
      if (gapped) continue;
      col = ((hc + m_xs[m_act][s]) % 1024) % TW;
      if (m_hf[m_act][s] != 0) col = TW - 1 - col;
      row = (vc - m_yt[m_act][s]) % TH;
      idx = m_pat[m_act][s]*TW*TH + row*TW + col;
      return pal(rv[2*idx +: 2]);
    end
    return BG;
  endfunction

  task automatic model_reset();
    m_act = 0; m_pend = 0; m_pbank = 0; m_err = 0;
    for (int b = 0; b < 2; b++)
      for (int s = 0; s < NS; s++) begin
        m_en[b][s] = 0; m_hf[b][s] = 0; m_pat[b][s] = 0; m_xs[b][s] = 0; m_yt[b][s] = 0;
        for (int g = 0; g < NG; g++) begin m_gl[b][s][g] = 1023; m_gr[b][s][g] = 0; end
      end
  endtask

  task automatic model_step(bit wv, logic [31:0] wd, int hc, int vc);
    int old_act, st, ty, bk, gi;
    logic [12:0] msg;
    old_act = m_act;
    st = int'(wd[25:21]); ty = int'(wd[16:14]); bk = int'(wd[13]); msg = wd[12:0];
    gi = int'(msg[12:10]);
    if (hc == 0 && vc == 480 && m_pend != 0) begin m_act = m_pbank; m_pend = 0; end
    if (wv && wd[20:17] == 4'hF) begin
      m_pend = 1; m_pbank = bk;
    end else if (wv && wd[20:17] == 4'h1 && wd[31:26] == ID) begin
      if (bk == old_act || st >= NS || ((ty == 4 || ty == 5) && gi >= NG)) m_err = 1;
      else case (ty)
        1: begin
          m_en[bk][st] = int'(msg[12]); m_hf[bk][st] = int'(msg[11]);
          if (int'(msg[4:0]) >= NP) m_err = 1; else m_pat[bk][st] = int'(msg[4:0]);
        end
        2: m_xs[bk][st] = int'(msg[9:0]);
        3: m_yt[bk][st] = int'(msg[9:0]);
        4: m_gl[bk][st][gi] = int'(msg[9:0]);
        5: m_gr[bk][st][gi] = int'(msg[9:0]);
        default: ;
      endcase
    end
  endtask

  task automatic tick(bit wv, logic [31:0] wd, int hc, int vc);
    logic [23:0] e;
    bus.write_valid = wv; bus.writedata = wd;
    bus.hcount = 10'(hc); bus.vcount = 10'(vc);
    e = model_pix(hc, vc);
    @(posedge clk);
    model_step(wv, wd, hc, vc);
    expq.push_back(e);
    #1;
    check("rgb", bus.RGB_output, expq.pop_front());
    check("active_bank", 24'(bus.active_bank), 24'(m_act));
    check("cmd_err", 24'(bus.cmd_err), 24'(m_err));
  endtask

  task automatic hold(int hc, int vc, int n);
    repeat (n) tick(1'b0, 32'h0, hc, vc);
  endtask

  task automatic do_reset();
    bus.write_valid = 1'b0;
    #3 reset = 1'b0;
    #1;
    check("rst_rgb", bus.RGB_output, BG);
    check("rst_bank", 24'(bus.active_bank), 24'h0);
    check("rst_err", 24'(bus.cmd_err), 24'h0);
    model_reset();
    expq = '{BG, BG};
    @(negedge clk);
    check("rst_rgb_hold", bus.RGB_output, BG);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 32'h0, 5, 10);
      check("post_rst_rgb", bus.RGB_output, BG);
    end
  endtask

  function automatic logic [31:0] scmd(int st, int ty, int bk, logic [12:0] msg);
    return {ID, 5'(st), 4'h1, 3'(ty), 1'(bk), msg};
  endfunction

  function automatic logic [31:0] swp(int bk);
    return {6'h0, 5'h0, 4'hF, 3'h0, 1'(bk), 13'h0};
  endfunction

  task automatic cmd(logic [31:0] w);
    tick(1'b1, w, 7, 7);
  endtask

  initial begin
    logic [31:0] wd;
    logic [12:0] msg;
    bit wv;
    int hc, vc, r, st, ty, bk;
    reset = 1'b0;
    bus.write_valid = 1'b0; bus.writedata = '0; bus.hcount = '0; bus.vcount = '0;
    model_reset();
    expq = '{BG, BG};
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    hold(3, 3, 2);
    do_reset();

    // Bank 1 strip 0 at ytop 368, armed during the frame, visible only after the commit line
    cmd(scmd(0, 1, 1, 13'h1000));
    cmd(scmd(0, 3, 1, 13'd368));
    cmd(scmd(0, 2, 1, 13'd0));
    tick(1'b1, swp(1), 50, 100);
    hold(0, 368, 3);
    check("pre_commit_bg", bus.RGB_output, BG);
    tick(1'b0, 32'h0, 0, 480);
    check("commit_bank1", 24'(bus.active_bank), 24'h1);
    hold(0, 368, 3);
    check("first_px", bus.RGB_output, 24'hFFFFFF);
    hold(5, 368, 3);
    check("px_h5", bus.RGB_output, 24'hD3D3D3);

    cmd(scmd(0, 1, 0, 13'h1000));
    cmd(scmd(0, 3, 0, 13'd368));
    cmd(scmd(0, 2, 0, 13'd5));
    tick(1'b1, swp(0), 0, 0);
    tick(1'b0, 32'h0, 0, 480);
    hold(0, 368, 3);
    check("xscroll5", bus.RGB_output, 24'hD3D3D3);

    cmd(scmd(0, 4, 1, 13'd100));
    cmd(scmd(0, 5, 1, 13'd199));
    tick(1'b1, swp(1), 0, 0);
    tick(1'b0, 32'h0, 0, 480);
    hold(99, 368, 3);  check("gap_h99", bus.RGB_output, 24'h808080);
    hold(100, 368, 3); check("gap_h100", bus.RGB_output, BG);
    hold(199, 368, 3); check("gap_h199", bus.RGB_output, BG);
    hold(200, 368, 3); check("gap_h200", bus.RGB_output, 24'hFFFFFF);

    cmd(scmd(0, 2, 0, 13'd0));
    cmd(scmd(0, 4, 0, 13'd300));
    cmd(scmd(0, 5, 0, 13'd200));
    tick(1'b1, swp(0), 0, 0);
    tick(1'b0, 32'h0, 0, 480);
    hold(150, 368, 3);
    check("gap_disabled", bus.RGB_output, 24'h808080);

    cmd(scmd(0, 3, 0, 13'd0));
    check("err_active_bank", 24'(bus.cmd_err), 24'h1);
    hold(150, 368, 3);
    check("active_unchanged", bus.RGB_output, 24'h808080);
    cmd(scmd(2, 3, 1, 13'd0));
    hold(3, 3, 2);
    check("err_sticky", 24'(bus.cmd_err), 24'h1);

    tick(1'b1, swp(1), 3, 3);
    tick(1'b1, swp(0), 0, 480);
    check("swap_at_commit", 24'(bus.active_bank), 24'h1);
    tick(1'b0, 32'h0, 0, 480);
    check("second_commit", 24'(bus.active_bank), 24'h0);

    for (int i = 0; i < 3000; i++) begin
      if (i % 750 == 0) do_reset();
      wv = 1'b0; wd = $urandom;
      hc = $urandom_range(0, 1023);
      r = $urandom_range(0, 99);
      vc = (r < 50) ? $urandom_range(0, 63) : (r < 80) ? $urandom_range(350, 420) : $urandom_range(0, 1023);
      if ($urandom_range(0, 19) == 0) begin hc = 0; vc = 480; end
      if ($urandom_range(0, 9) < 4) begin
        wv = 1'b1;
        if ($urandom_range(0, 9) == 0) begin
          wd[20:17] = 4'hF;
        end else begin
          st = $urandom_range(0, 3);
          if (st == 3) st = $urandom_range(0, 31);
          ty = $urandom_range(0, 7);
          bk = ($urandom_range(0, 4) == 0) ? m_act : 1 - m_act;
          msg = 13'($urandom_range(0, 8191));
          if (ty == 1) begin
            msg[12] = ($urandom_range(0, 3) != 0);
            msg[4:0] = 5'($urandom_range(0, 2));
          end
          if (ty == 3) begin
            case ($urandom_range(0, 3))
              0: msg[9:0] = 10'd0;
              1: msg[9:0] = 10'd16;
              2: msg[9:0] = 10'd368;
              default: ;
            endcase
          end
          if (ty == 4 || ty == 5) msg[12:10] = 3'($urandom_range(0, 2));
          wd = scmd(st, ty, bk, msg);
          if ($urandom_range(0, 19) == 0) wd[31:26] = 6'($urandom);
          if ($urandom_range(0, 19) == 0) wd[20:17] = 4'($urandom);
        end
      end
      tick(wv, wd, hc, vc);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
